// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - SECDED code geometry, encoder and error classes.
package secded_pkg;

  typedef enum logic [1:0] {ERR_NONE, ERR_SINGLE, ERR_DOUBLE} err_class_t;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CHK_W  = 8;

  function automatic int secded_p(input int data_w);
    int p;
    p = 1;
    for (int i = 1; i < 8; i++) begin
      if ((1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  // Codeword position of data bit k: the k-th non-power-of-two position from 3 up.
  function automatic int data_pos(input int k);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int pos = 3; pos < 128; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == k) res = pos;
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  function automatic logic [MAX_CHK_W-1:0] secded_encode(input logic [MAX_DATA_W-1:0] data,
                                                         input int data_w);
    logic [MAX_CHK_W-1:0] chk;
    logic par;
    int k;
    int p;
    p   = secded_p(data_w);
    chk = '0;
    k   = 0;
    for (int pos = 3; pos < 128; pos++) begin
      if (((pos & (pos - 1)) != 0) && (k < data_w)) begin
        for (int i = 0; i < 7; i++) begin
          if (((pos >> i) & 1) != 0) chk[i[2:0]] = chk[i[2:0]] ^ data[k[5:0]];
        end
        k = k + 1;
      end
    end
    par = 1'b0;
    for (int j = 0; j < MAX_DATA_W; j++) begin
      if (j < data_w) par = par ^ data[j[5:0]];
    end
    for (int i = 0; i < 7; i++) begin
      if (i < p) par = par ^ chk[i[2:0]];
    end
    chk[p[2:0]] = par;
    return chk;
  endfunction

endpackage

// File: rtl/secded_sat_counter.sv
// rtl/secded_sat_counter.sv - saturating event counter with clear priority.
module secded_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/secded_stream_corrector.sv
// rtl/secded_stream_corrector.sv - two-stage SECDED corrector with valid/ready stream ports.
module secded_stream_corrector
  import secded_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int P      = secded_p(DATA_W),
  localparam int CHK_W  = P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_single,
  output logic              out_err_double,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_unc
);

  localparam int N_POS = DATA_W + P;

  logic              adv;
  logic [P-1:0]      ham;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [P-1:0]      s1_syn;
  logic              s1_par_err;
  err_class_t        cls;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] corr_data;

  // Whole pipeline moves together, so a stall freezes every stage at once.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign ham = P'(secded_encode(MAX_DATA_W'(in_data), DATA_W));

  always_comb begin
    cls = ERR_NONE;
    if (s1_syn == '0) begin
      cls = s1_par_err ? ERR_SINGLE : ERR_NONE;
    end else if (s1_par_err && (32'(s1_syn) <= N_POS)) begin
      cls = ERR_SINGLE;
    end else begin
      cls = ERR_DOUBLE;
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_flip
    localparam int POS = data_pos(k);
    assign flip_mask[k] = (32'(s1_syn) == POS);
  end

  // A syndrome naming a check position leaves the mask empty, so data passes unchanged.
  assign corr_data = ((cls == ERR_SINGLE) && correct_en) ? (s1_data ^ flip_mask) : s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      s1_syn         <= '0;
      s1_par_err     <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err_single <= 1'b0;
      out_err_double <= 1'b0;
    end else if (adv) begin
      s1_valid       <= in_valid;
      s1_data        <= in_data;
      s1_syn         <= ham ^ in_chk[P-1:0];
      s1_par_err     <= ^{in_data, in_chk};
      out_valid      <= s1_valid;
      out_data       <= corr_data;
      out_err_single <= s1_valid && (cls == ERR_SINGLE);
      out_err_double <= s1_valid && (cls == ERR_DOUBLE);
    end
  end

  logic hs_corr;
  logic hs_unc;
  assign hs_corr = out_valid & out_ready & out_err_single;
  assign hs_unc  = out_valid & out_ready & out_err_double;

  secded_sat_counter #(.CNT_W(CNT_W)) u_cnt_corr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs_corr),
    .clr   (cnt_clr),
    .cnt   (cnt_corr)
  );

  secded_sat_counter #(.CNT_W(CNT_W)) u_cnt_unc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs_unc),
    .clr   (cnt_clr),
    .cnt   (cnt_unc)
  );

endmodule

// File: tb/tb_secded_stream_corrector.sv
// tb/tb_secded_stream_corrector.sv - directed bench for secded_stream_corrector.
module tb_secded_stream_corrector;
  import secded_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CHK_W  = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              correct_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err_single;
  logic              out_err_double;
  logic              cnt_clr;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_unc;

  int total = 0;
  int bad   = 0;

  secded_stream_corrector #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_chk         (in_chk),
    .correct_en     (correct_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err_single (out_err_single),
    .out_err_double (out_err_double),
    .cnt_clr        (cnt_clr),
    .cnt_corr       (cnt_corr),
    .cnt_unc        (cnt_unc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single isolated word with out_ready=1: accept edge, stage-1 edge, handshake edge.
  task automatic send_one(input logic [31:0] d, input logic [6:0] c, input logic en,
                          input logic [31:0] exp_d, input logic exp_s, input logic exp_dbl,
                          input int exp_corr, input int exp_unc, input string tag);
    in_valid   = 1'b1;
    in_data    = d;
    in_chk     = c;
    correct_en = en;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_single"}, out_err_single, exp_s);
    check({tag, "_double"}, out_err_double, exp_dbl);
    tick();
    check({tag, "_drain"}, out_valid, 1'b0);
    check({tag, "_cnt_corr"}, cnt_corr, exp_corr);
    check({tag, "_cnt_unc"}, cnt_unc, exp_unc);
    correct_en = 1'b1;
  endtask

  logic [31:0] bp_d [4];
  logic [6:0]  bp_c [4];
  int sent;
  int rcvd;

  initial begin
    bp_d = '{32'h1, 32'h2, 32'h4, 32'h8};
    bp_c = '{7'h43, 7'h45, 7'h46, 7'h07};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_chk     = '0;
    correct_en = 1'b1;
    out_ready  = 1'b1;
    cnt_clr    = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_single", out_err_single, 1'b0);
    check("rst_double", out_err_double, 1'b0);
    check("rst_cnt_corr", cnt_corr, 4'd0);
    check("rst_cnt_unc", cnt_unc, 4'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check("enc_deadbeef", secded_encode(64'hDEADBEEF, 32), 8'h63);
    check("enc_one", secded_encode(64'h1, 32), 8'h43);

    send_one(32'hDEADBEEF, 7'h63, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, "clean");
    send_one(32'hDEADBECF, 7'h63, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1, 0, "d5_fix");
    send_one(32'hDEADBECF, 7'h63, 1'b0, 32'hDEADBECF, 1'b1, 1'b0, 2, 0, "d5_raw");
    send_one(32'hDEADBEEF, 7'h6B, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3, 0, "chk3");
    send_one(32'hDEADBEEF, 7'h23, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4, 0, "chk6");
    send_one(32'h5EADBEEE, 7'h63, 1'b1, 32'h5EADBEEE, 1'b0, 1'b1, 4, 1, "dbl");
    send_one(32'hDEADBEEF, 7'h4A, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4, 2, "syn_oob");

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_corr", cnt_corr, 4'd0);
    check("clr_unc", cnt_unc, 4'd0);

    // Backpressure: consumer stalls during cycles 2..5.
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_data = bp_d[sent];
        in_chk  = bp_c[sent];
      end
      #1;
      if (c < 8) check($sformatf("bp_in_ready_c%0d", c), in_ready, (c < 2 || c > 5));
      if (c >= 2 && c <= 5) begin
        check($sformatf("bp_hold_valid_c%0d", c), out_valid, 1'b1);
        check($sformatf("bp_hold_data_c%0d", c), out_data, bp_d[0]);
      end
      if (out_valid && out_ready) begin
        if (rcvd < 4) check($sformatf("bp_order_%0d", rcvd), out_data, bp_d[rcvd]);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", sent, 4);
    check("bp_rcvd", rcvd, 4);
    check("bp_cnt_corr", cnt_corr, 4'd0);

    // Saturation: 20 parity-bit-only errors back to back.
    in_data  = 32'h0;
    in_chk   = 7'h40;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("sat_mid", cnt_corr, 4'd8);
    for (int i = 0; i < 10; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("sat_corr", cnt_corr, 4'd15);
    check("sat_unc", cnt_unc, 4'd0);

    // Clear lands on the same edge as an error-word handshake.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("clrhs_single", out_err_single, 1'b1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clrhs_corr", cnt_corr, 4'd0);

    // Reset with two words in flight.
    in_valid = 1'b1;
    in_data  = bp_d[0];
    in_chk   = bp_c[0];
    tick();
    in_data  = bp_d[1];
    in_chk   = bp_c[1];
    tick();
    in_valid = 1'b0;
    check("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data", out_data, 32'h0);
    check("arst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle1", out_valid, 1'b0);
    tick();
    check("post_rst_idle2", out_valid, 1'b0);
    send_one(32'h4, 7'h46, 1'b1, 32'h4, 1'b0, 1'b0, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
